// File: rtl/pkt_queue_dma_wr_if.sv
// -----------------------------------------------------------------------------
// pkt_queue_dma_wr_if
// Bundles every non-clock/reset signal of pkt_queue_dma_wr.
//   Flit stream in     : pkt_buf_data {data, sop, eop}, pkt_buf_valid/ready
//   Metadata in        : meta_buf_data {dsc_queue_id, pkt_queue_id, size},
//                        meta_buf_valid/ready
//   Head pointer write : head_wr_en, head_wr_queue, head_wr_value
//   DMA write out      : dma_wr_data/queue/offset/sop/eop, dma_wr_valid/ready
//   Descriptor out     : dsc_valid/ready, dsc_app_queue, dsc_pkt_queue,
//                        dsc_tail, dsc_size
//   Status             : drop_cnt, size_err
// Flit layout  : [DATA_W+1:2] data, [1] sop, [0] eop.
// Meta layout  : [META_W-1 -: APP_IDX_WIDTH] dsc_queue_id,
//                [SIZE_W +: PQ_ID_W] pkt_queue_id, [SIZE_W-1:0] size.
// Modport slave is the DUT side, master is the environment side.
// -----------------------------------------------------------------------------
interface pkt_queue_dma_wr_if #(
    parameter int NB_PKT_QUEUES = 16,
    parameter int RB_AW         = 10,
    parameter int DATA_W        = 512,
    parameter int APP_IDX_WIDTH = 8,
    parameter int PQ_ID_W       = 8,
    parameter int SIZE_W        = 16
);
    localparam int QW     = $clog2(NB_PKT_QUEUES);
    localparam int FLIT_W = DATA_W + 2;
    localparam int META_W = APP_IDX_WIDTH + PQ_ID_W + SIZE_W;

    logic [FLIT_W-1:0]        pkt_buf_data;
    logic                     pkt_buf_valid;
    logic                     pkt_buf_ready;
    logic [META_W-1:0]        meta_buf_data;
    logic                     meta_buf_valid;
    logic                     meta_buf_ready;
    logic                     head_wr_en;
    logic [QW-1:0]            head_wr_queue;
    logic [RB_AW-1:0]         head_wr_value;
    logic [DATA_W-1:0]        dma_wr_data;
    logic [QW-1:0]            dma_wr_queue;
    logic [RB_AW-1:0]         dma_wr_offset;
    logic                     dma_wr_sop;
    logic                     dma_wr_eop;
    logic                     dma_wr_valid;
    logic                     dma_wr_ready;
    logic                     dsc_valid;
    logic                     dsc_ready;
    logic [APP_IDX_WIDTH-1:0] dsc_app_queue;
    logic [QW-1:0]            dsc_pkt_queue;
    logic [RB_AW-1:0]         dsc_tail;
    logic [SIZE_W-1:0]        dsc_size;
    logic [31:0]              drop_cnt;
    logic                     size_err;

    modport slave (
        input  pkt_buf_data, pkt_buf_valid,
        output pkt_buf_ready,
        input  meta_buf_data, meta_buf_valid,
        output meta_buf_ready,
        input  head_wr_en, head_wr_queue, head_wr_value,
        output dma_wr_data, dma_wr_queue, dma_wr_offset, dma_wr_sop, dma_wr_eop,
        output dma_wr_valid,
        input  dma_wr_ready,
        output dsc_valid,
        input  dsc_ready,
        output dsc_app_queue, dsc_pkt_queue, dsc_tail, dsc_size,
        output drop_cnt, size_err
    );

    modport master (
        output pkt_buf_data, pkt_buf_valid,
        input  pkt_buf_ready,
        output meta_buf_data, meta_buf_valid,
        input  meta_buf_ready,
        output head_wr_en, head_wr_queue, head_wr_value,
        input  dma_wr_data, dma_wr_queue, dma_wr_offset, dma_wr_sop, dma_wr_eop,
        input  dma_wr_valid,
        output dma_wr_ready,
        input  dsc_valid,
        output dsc_ready,
        input  dsc_app_queue, dsc_pkt_queue, dsc_tail, dsc_size,
        input  drop_cnt, size_err
    );
endinterface

// File: rtl/pkt_queue_dma_wr.sv
// -----------------------------------------------------------------------------
// pkt_queue_dma_wr
// Writes packets into per-queue host ring buffers. For each metadata entry the
// free space of the target ring is checked; the packet's flits are either
// forwarded as DMA writes (tagged with queue and ring offset) followed by one
// descriptor, or consumed and dropped as a whole.
// Ports:
//   clk  - clock
//   rst  - asynchronous, active-high reset
//   bus  - pkt_queue_dma_wr_if.slave: flit/metadata inputs, head pointer
//          writes, DMA write output, descriptor output, drop_cnt, size_err
// -----------------------------------------------------------------------------
module pkt_queue_dma_wr #(
    parameter int NB_PKT_QUEUES = 16,
    parameter int RB_SIZE       = 1024,
    parameter int RB_AW         = 10,
    parameter int DATA_W        = 512,
    parameter int APP_IDX_WIDTH = 8,
    parameter int PQ_ID_W       = 8,
    parameter int SIZE_W        = 16
) (
    input logic               clk,
    input logic               rst,
    pkt_queue_dma_wr_if.slave bus
);
    localparam int QW     = $clog2(NB_PKT_QUEUES);
    localparam int FLIT_W = DATA_W + 2;
    localparam int META_W = APP_IDX_WIDTH + PQ_ID_W + SIZE_W;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        XFER,
        DSC,
        DROP
    } state_t;

    // Occupancy: one slot is kept empty so head==tail means an empty ring.
    function automatic logic [RB_AW-1:0] free_space(input logic [RB_AW-1:0] head,
                                                    input logic [RB_AW-1:0] tail);
        return head - tail - RB_AW'(1);
    endfunction

    function automatic logic [RB_AW-1:0] ring_inc(input logic [RB_AW-1:0] off);
        return (off == RB_AW'(RB_SIZE - 1)) ? '0 : off + RB_AW'(1);
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    state_t state, state_nxt;

    logic [RB_AW-1:0] head_mem [NB_PKT_QUEUES];
    logic [RB_AW-1:0] tail_mem [NB_PKT_QUEUES];

    logic [APP_IDX_WIDTH-1:0] app_q_p0;
    logic [QW-1:0]            pq_p0;
    logic [SIZE_W-1:0]        size_p0;

    logic [RB_AW-1:0]  off_p1;
    logic [SIZE_W-1:0] cnt_p1;

    logic [31:0] drop_cnt_r;
    logic        size_err_r;

    logic [DATA_W-1:0]        flit_data;
    logic                     flit_sop;
    logic                     flit_eop;
    logic [SIZE_W-1:0]        meta_size;
    logic [QW-1:0]            meta_pq;
    logic [APP_IDX_WIDTH-1:0] meta_app;
    logic                     unused_meta_bits;

    logic             meta_rdy;
    logic             pkt_rdy;
    logic             wr_vld;
    logic             dsc_vld;
    logic             meta_hs;
    logic             xfer_hs;
    logic             drop_hs;
    logic [RB_AW-1:0] free_now;
    logic             fit;

    assign flit_data = bus.pkt_buf_data[FLIT_W-1:2];
    assign flit_sop  = bus.pkt_buf_data[1];
    assign flit_eop  = bus.pkt_buf_data[0];

    assign meta_size = bus.meta_buf_data[SIZE_W-1:0];
    assign meta_pq   = bus.meta_buf_data[SIZE_W +: QW];
    assign meta_app  = bus.meta_buf_data[META_W-1 -: APP_IDX_WIDTH];
    // Upper pkt_queue_id bits above QW select nothing.
    assign unused_meta_bits = ^bus.meta_buf_data[SIZE_W+QW +: PQ_ID_W-QW];

    // Head reads here see the value before any same-cycle head write, which
    // can only understate the free space.
    assign free_now = free_space(head_mem[pq_p0], tail_mem[pq_p0]);
    assign fit      = (size_p0 != '0) && (32'(size_p0) <= 32'(free_now));

    always_comb begin
        state_nxt = state;
        meta_rdy  = 1'b0;
        pkt_rdy   = 1'b0;
        wr_vld    = 1'b0;
        dsc_vld   = 1'b0;
        case (state)
            IDLE: begin
                // Gated by rst so no ready is visible while reset is held.
                meta_rdy = !rst;
                if (bus.meta_buf_valid && !rst) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                state_nxt = fit ? XFER : DROP;
            end
            XFER: begin
                wr_vld  = bus.pkt_buf_valid;
                pkt_rdy = bus.dma_wr_ready;
                if (bus.pkt_buf_valid && bus.dma_wr_ready && flit_eop) begin
                    state_nxt = DSC;
                end
            end
            DSC: begin
                dsc_vld = 1'b1;
                if (bus.dsc_ready) begin
                    state_nxt = IDLE;
                end
            end
            DROP: begin
                pkt_rdy = 1'b1;
                if (bus.pkt_buf_valid && flit_eop) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign meta_hs = meta_rdy && bus.meta_buf_valid;
    assign xfer_hs = (state == XFER) && bus.pkt_buf_valid && bus.dma_wr_ready;
    assign drop_hs = (state == DROP) && bus.pkt_buf_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NB_PKT_QUEUES; i++) begin
                head_mem[i] <= '0;
            end
        end else if (bus.head_wr_en) begin
            head_mem[bus.head_wr_queue] <= bus.head_wr_value;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NB_PKT_QUEUES; i++) begin
                tail_mem[i] <= '0;
            end
        end else if (xfer_hs && flit_eop) begin
            tail_mem[pq_p0] <= ring_inc(off_p1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_r <= '0;
            size_err_r <= 1'b0;
        end else begin
            if (drop_hs && flit_eop) begin
                drop_cnt_r <= sat_inc32(drop_cnt_r);
            end
            // cnt_p1 is the pre-increment count, so >= means the new count
            // exceeds the advertised size.
            if (xfer_hs && (32'(cnt_p1) >= 32'(size_p0))) begin
                size_err_r <= 1'b1;
            end
        end
    end

    // ---- stage p0: metadata capture on the IDLE handshake ----
    always_ff @(posedge clk) begin
        if (meta_hs) begin
            app_q_p0 <= meta_app;
            pq_p0    <= meta_pq;
            size_p0  <= meta_size;
        end
    end

    // ---- stage p1: ring offset and flit count, loaded in CHECK ----
    always_ff @(posedge clk) begin
        if (state == CHECK) begin
            off_p1 <= tail_mem[pq_p0];
            cnt_p1 <= '0;
        end else if (xfer_hs) begin
            off_p1 <= ring_inc(off_p1);
            cnt_p1 <= cnt_p1 + SIZE_W'(1);
        end
    end

    assign bus.meta_buf_ready = meta_rdy;
    assign bus.pkt_buf_ready  = pkt_rdy;

    assign bus.dma_wr_valid  = wr_vld;
    assign bus.dma_wr_data   = flit_data;
    assign bus.dma_wr_sop    = flit_sop;
    assign bus.dma_wr_eop    = flit_eop;
    assign bus.dma_wr_queue  = pq_p0;
    assign bus.dma_wr_offset = off_p1;

    assign bus.dsc_valid     = dsc_vld;
    assign bus.dsc_app_queue = app_q_p0;
    assign bus.dsc_pkt_queue = pq_p0;
    assign bus.dsc_tail      = tail_mem[pq_p0];
    assign bus.dsc_size      = cnt_p1;

    assign bus.drop_cnt = drop_cnt_r;
    assign bus.size_err = size_err_r;

endmodule

// File: tb/tb_pkt_queue_dma_wr.sv
module tb_pkt_queue_dma_wr;
    localparam int NQ = 16;
    localparam int RB = 1024;
    localparam int AW = 10;
    localparam int DW = 512;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pkt_queue_dma_wr_if #(
        .NB_PKT_QUEUES(NQ), .RB_AW(AW), .DATA_W(DW),
        .APP_IDX_WIDTH(8), .PQ_ID_W(8), .SIZE_W(16)
    ) bus ();

    pkt_queue_dma_wr #(
        .NB_PKT_QUEUES(NQ), .RB_SIZE(RB), .RB_AW(AW), .DATA_W(DW),
        .APP_IDX_WIDTH(8), .PQ_ID_W(8), .SIZE_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: ring pointers and status, updated from the rules only.
    int          head_m [NQ];
    int          tail_m [NQ];
    logic [31:0] drop_m;
    bit          serr_m;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NQ; i++) begin
            head_m[i] = 0;
            tail_m[i] = 0;
        end
        drop_m = 0;
        serr_m = 0;
    endtask

    task automatic write_head(input int q, input int v);
        @(negedge clk);
        bus.head_wr_en    = 1'b1;
        bus.head_wr_queue = 4'(q);
        bus.head_wr_value = 10'(v);
        @(negedge clk);
        bus.head_wr_en = 1'b0;
        head_m[q] = v % RB;
    endtask

    // mode: 0 = always valid/ready, 1 = random gaps, 2 = ready toggles 1,0,1,0
    task automatic send_packet(input int q, input int app, input int size,
                               input int nflits, input int mode, input int dsc_hold);
        int qi, free_v, exp_off, sent, guard, cyc, hold;
        bit fit, v, r, hs;
        logic [511:0] d;
        qi      = q % NQ;
        free_v  = (head_m[qi] - tail_m[qi] - 1 + 2 * RB) % RB;
        fit     = (size != 0) && (size <= free_v);
        exp_off = tail_m[qi];
        sent    = 0;

        @(negedge clk);
        bus.meta_buf_data  = {8'(app), 8'(q), 16'(size)};
        bus.meta_buf_valid = 1'b1;
        #1;
        guard = 0;
        while (bus.meta_buf_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            #1;
            guard++;
        end
        chk("meta_ready_idle", bus.meta_buf_ready, 1'b1);

        // CHECK cycle: a presented flit must not be taken.
        @(negedge clk);
        bus.meta_buf_valid = 1'b0;
        d = rnd512();
        bus.pkt_buf_data  = {d, 1'b1, (nflits == 1)};
        bus.pkt_buf_valid = 1'b1;
        bus.dma_wr_ready  = 1'b1;
        #1;
        chk("check_pkt_ready", bus.pkt_buf_ready, 1'b0);
        chk("check_meta_ready", bus.meta_buf_ready, 1'b0);

        guard = 0;
        cyc   = 0;
        while (sent < nflits && guard < nflits * 8 + 20) begin
            @(negedge clk);
            guard++;
            case (mode)
                1: begin v = ($urandom_range(0, 3) != 0); r = ($urandom_range(0, 2) != 0); end
                2: begin v = 1'b1; r = (cyc % 2 == 0); end
                default: begin v = 1'b1; r = 1'b1; end
            endcase
            cyc++;
            bus.pkt_buf_data  = {d, (sent == 0), (sent == nflits - 1)};
            bus.pkt_buf_valid = v;
            bus.dma_wr_ready  = r;
            #1;
            if (fit) begin
                chk("xfer_valid", bus.dma_wr_valid, v);
                chk("xfer_pkt_ready", bus.pkt_buf_ready, r);
                if (v) begin
                    chk("xfer_offset", bus.dma_wr_offset, exp_off);
                    chk("xfer_queue", bus.dma_wr_queue, qi);
                    chk("xfer_data", bus.dma_wr_data, d);
                    chk("xfer_sop", bus.dma_wr_sop, (sent == 0));
                    chk("xfer_eop", bus.dma_wr_eop, (sent == nflits - 1));
                end
                hs = v && r;
            end else begin
                chk("drop_no_wr_valid", bus.dma_wr_valid, 1'b0);
                chk("drop_pkt_ready", bus.pkt_buf_ready, 1'b1);
                hs = v;
            end
            if (hs) begin
                sent++;
                if (fit) begin
                    exp_off = (exp_off + 1) % RB;
                    if (sent > size) serr_m = 1'b1;
                end
                d = rnd512();
            end
        end
        if (sent != nflits) chk("flit_timeout", sent, nflits);

        if (fit) begin
            tail_m[qi] = exp_off;
            hold = dsc_hold;
            for (int k = 0; k <= dsc_hold; k++) begin
                @(negedge clk);
                bus.pkt_buf_valid = 1'b0;
                bus.dsc_ready     = (hold == 0);
                #1;
                chk("dsc_valid", bus.dsc_valid, 1'b1);
                chk("dsc_meta_blocked", bus.meta_buf_ready, 1'b0);
                chk("dsc_tail", bus.dsc_tail, exp_off);
                chk("dsc_size", bus.dsc_size, nflits);
                chk("dsc_pkt_queue", bus.dsc_pkt_queue, qi);
                chk("dsc_app_queue", bus.dsc_app_queue, app % 256);
                hold--;
            end
        end else begin
            if (drop_m != 32'hFFFF_FFFF) drop_m = drop_m + 1;
        end

        @(negedge clk);
        bus.pkt_buf_valid = 1'b0;
        bus.dsc_ready     = 1'b0;
        #1;
        chk("post_idle_meta_ready", bus.meta_buf_ready, 1'b1);
        chk("post_dsc_valid", bus.dsc_valid, 1'b0);
        chk("post_drop_cnt", bus.drop_cnt, drop_m);
        chk("post_size_err", bus.size_err, serr_m);
    endtask

    initial begin
        int q, sz, nf;
        rst                = 1'b1;
        bus.pkt_buf_data   = '0;
        bus.pkt_buf_valid  = 1'b0;
        bus.meta_buf_data  = '0;
        bus.meta_buf_valid = 1'b0;
        bus.head_wr_en     = 1'b0;
        bus.head_wr_queue  = '0;
        bus.head_wr_value  = '0;
        bus.dma_wr_ready   = 1'b0;
        bus.dsc_ready      = 1'b0;
        model_reset();

        repeat (3) @(negedge clk);
        #1;
        chk("rst_meta_ready", bus.meta_buf_ready, 1'b0);
        chk("rst_pkt_ready", bus.pkt_buf_ready, 1'b0);
        chk("rst_wr_valid", bus.dma_wr_valid, 1'b0);
        chk("rst_dsc_valid", bus.dsc_valid, 1'b0);
        chk("rst_drop_cnt", bus.drop_cnt, 32'd0);
        chk("rst_size_err", bus.size_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Fit on an empty queue
        send_packet(3, 8'h21, 4, 4, 0, 0);

        // Ring wrap: move tail to 1022, then head=tail=1022
        write_head(0, 1023);
        send_packet(0, 8'h01, 1022, 1022, 0, 0);
        write_head(0, 1022);
        send_packet(0, 8'h02, 3, 3, 0, 0);

        // Full ring: tail=10, head=12 leaves one slot; then confirm tail held
        write_head(5, 20);
        send_packet(5, 8'h05, 10, 10, 0, 0);
        write_head(5, 12);
        send_packet(5, 8'h06, 2, 2, 0, 0);
        write_head(5, 20);
        send_packet(5, 8'h07, 1, 1, 0, 0);

        // Zero-size metadata always drops
        send_packet(6, 8'h08, 0, 2, 0, 0);

        // Backpressure toggling plus a held descriptor
        send_packet(7, 8'h09, 2, 2, 2, 5);

        // More flits than advertised
        send_packet(9, 8'h0A, 2, 3, 0, 0);

        // Randomized traffic, upper queue-id bits set, heads near tails
        for (int n = 0; n < 40; n++) begin
            q  = $urandom_range(0, 255);
            sz = $urandom_range(0, 6);
            nf = (sz == 0) ? $urandom_range(1, 3) : sz + ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 2) == 0)
                write_head(q % NQ, (tail_m[q % NQ] + $urandom_range(0, 8)) % RB);
            send_packet(q, $urandom_range(0, 255), sz, nf, 1, $urandom_range(0, 3));
        end

        // Reset in the middle of a packet
        write_head(2, tail_m[2]);
        @(negedge clk);
        bus.meta_buf_data  = {8'h11, 8'd2, 16'd4};
        bus.meta_buf_valid = 1'b1;
        #1;
        chk("mid_meta_ready", bus.meta_buf_ready, 1'b1);
        @(negedge clk);
        bus.meta_buf_valid = 1'b0;
        bus.pkt_buf_data   = {rnd512(), 1'b1, 1'b0};
        bus.pkt_buf_valid  = 1'b1;
        bus.dma_wr_ready   = 1'b1;
        #1;
        chk("mid_check_ready", bus.pkt_buf_ready, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.pkt_buf_data = {rnd512(), (i == 0), 1'b0};
            #1;
            chk("mid_wr_valid", bus.dma_wr_valid, 1'b1);
            chk("mid_offset", bus.dma_wr_offset, (tail_m[2] + i) % RB);
        end
        @(negedge clk);
        bus.pkt_buf_data = {rnd512(), 1'b0, 1'b0};
        rst = 1'b1;
        #1;
        chk("midrst_wr_valid", bus.dma_wr_valid, 1'b0);
        chk("midrst_pkt_ready", bus.pkt_buf_ready, 1'b0);
        chk("midrst_meta_ready", bus.meta_buf_ready, 1'b0);
        chk("midrst_dsc_valid", bus.dsc_valid, 1'b0);
        chk("midrst_drop_cnt", bus.drop_cnt, 32'd0);
        chk("midrst_size_err", bus.size_err, 1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.pkt_buf_valid = 1'b0;

        // Fresh packet after reset lands at offset 0
        send_packet(2, 8'h12, 2, 2, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pkt_queue_dma_wr.md
Name: pkt_queue_dma_wr

Overview:
- Consumes the packet-flit stream and per-packet metadata stream produced by the PDU generation stage.
- Keeps a per-packet-queue ring-buffer tail pointer and a software-written head pointer.
- Checks free space for each packet, then either forwards its flits as DMA writes tagged with queue id and ring offset, or drops the whole packet.
- After every forwarded packet, emits one descriptor towards the descriptor-queue DMA logic.

Parameters:
- NB_PKT_QUEUES, 16, number of packet queues; power of two; QW = log2(NB_PKT_QUEUES).
- RB_SIZE, 1024, ring-buffer size per queue in 64-byte flits; power of two.
- RB_AW, 10, log2(RB_SIZE); width of head, tail and offset values.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- pkt_buf_data  in  $bits(flit_lite_t)  flit: data[511:0], sop, eop.
- pkt_buf_valid  in  1  flit valid.
- pkt_buf_ready  out  1  flit accept.
- meta_buf_data  in  $bits(pkt_meta_t)  dsc_queue_id, pkt_queue_id, size (flits).
- meta_buf_valid  in  1  metadata valid.
- meta_buf_ready  out  1  metadata accept.
- head_wr_en  in  1  head pointer update strobe.
- head_wr_queue  in  QW  queue being updated.
- head_wr_value  in  RB_AW  new head, in flits.
- dma_wr_data  out  512  flit payload.
- dma_wr_queue  out  QW  destination packet queue.
- dma_wr_offset  out  RB_AW  flit offset within the ring.
- dma_wr_sop  out  1  first flit of packet.
- dma_wr_eop  out  1  last flit of packet.
- dma_wr_valid  out  1  write valid.
- dma_wr_ready  in  1  write accept.
- dsc_valid  out  1  descriptor valid.
- dsc_ready  in  1  descriptor accept.
- dsc_app_queue  out  APP_IDX_WIDTH  dsc_queue_id from the metadata.
- dsc_pkt_queue  out  QW  packet queue.
- dsc_tail  out  RB_AW  tail value after the packet.
- dsc_size  out  16  flits actually written.
- drop_cnt  out  32  packets dropped; saturating.
- size_err  out  1  sticky: a packet's flit count exceeded its metadata size.

Behaviour:
- Reset (async): FSM to IDLE; all tails, heads, drop_cnt and size_err cleared; all valid and ready outputs 0.
- Queue index q = pkt_queue_id[QW-1:0]; the upper bits are ignored.
- Free space: free = (head[q] - tail[q] - 1) mod RB_SIZE. One slot is always reserved, so an empty ring has RB_SIZE-1 free.
- IDLE:
  - meta_buf_ready=1; pkt_buf_ready=0.
  - On meta handshake, register the metadata, go to CHECK.
- CHECK (exactly 1 cycle): compute fit = (size != 0) && (size <= free). Load off = tail[q] and cnt = 0. Go to XFER if fit, else DROP.
- XFER:
  - dma_wr_valid = pkt_buf_valid; pkt_buf_ready = dma_wr_ready; combinational pass-through, zero latency.
  - dma_wr_data, sop and eop come from the flit; dma_wr_queue = q; dma_wr_offset = off.
  - On each flit handshake: off = (off+1) mod RB_SIZE (wraps RB_SIZE-1 to 0); cnt++.
  - On the eop handshake: tail[q] = off after the increment; go to DSC.
  - If cnt exceeds size, set size_err; forwarding still continues until eop.
- DSC:
  - dsc_valid=1 with the registered fields; dsc_size = cnt, dsc_tail = updated tail.
  - Hold until dsc_ready, then return to IDLE. No new metadata is accepted while in DSC.
- DROP:
  - pkt_buf_ready=1; dma_wr_valid=0; consume flits until the eop handshake.
  - Then drop_cnt++ (saturate at 2^32-1), return to IDLE. Tail unchanged; no descriptor emitted.
- Head write: applied on the clock edge in any state. A CHECK in the same cycle uses the pre-write head, which is conservative because head only frees space.
- Flits arriving while in IDLE or CHECK are not accepted (pkt_buf_ready=0).
- Reset asserted mid-packet: state abandoned; the packet's remaining flits are treated as a new stream once metadata arrives again.
- Throughput: 1 flit/cycle in XFER; 3 overhead cycles per packet (IDLE, CHECK, DSC) when dsc_ready=1.

Test Plan:
- Fit: queue 3 empty, meta size=4, 4 flits sop..eop, dma_wr_ready=1 -> offsets 0,1,2,3 on queue 3; descriptor tail=4, size=4; drop_cnt=0.
- Wrap: queue 0 with head=tail=1022 (write head first), size=3 -> offsets 1022,1023,0; descriptor tail=1.
- Full: queue 5 with tail=10, head=12 (free=1), size=2 -> all flits consumed, no dma_wr_valid, no descriptor, drop_cnt=1, tail stays 10.
- Backpressure: dma_wr_ready toggles 1,0,1,0 over a 2-flit packet -> pkt_buf_ready mirrors it; offsets not advanced on stalled cycles. Then hold dsc_ready=0 for 5 cycles -> meta_buf_ready stays 0 until the descriptor is accepted.
- Size mismatch: meta size=2, 3 flits delivered -> all 3 forwarded, size_err=1, dsc_size=3, tail advanced by 3.
- Reset mid-packet: assert rst after the 2nd of 4 flits -> outputs deassert immediately; tails=0, drop_cnt=0; next fresh packet lands at offset 0.
